// File: rtl/adder_tree_pkg.sv
// Shared types and default sizing for the adder tree sequencer slice.
package adder_tree_pkg;

    localparam int DEF_ADDER_WIDTH = 11;
    localparam int DEF_NUM_OPS     = 8;
    localparam int DEF_TREE_LAT    = 2;

    localparam int SUM_W = DEF_ADDER_WIDTH + $clog2(DEF_NUM_OPS);
    localparam int IDX_W = $clog2(DEF_NUM_OPS);
    localparam int CNT_W = IDX_W + 1;
    localparam int LAT_W = $clog2(DEF_TREE_LAT + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/adder_tree_operand_bank.sv
// Operand slot registers feeding the adder tree; a slot-0 write starts a fresh group
// by zeroing every other slot so short groups sum exactly.
module adder_tree_operand_bank
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int NUM_OPS     = DEF_NUM_OPS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [$clog2(NUM_OPS)-1:0]       wr_idx,
    input  logic [ADDER_WIDTH-1:0]           wr_data,
    output logic [NUM_OPS*ADDER_WIDTH-1:0]   op_bus
);

    localparam int IDX_BITS = $clog2(NUM_OPS);

    logic [ADDER_WIDTH-1:0] slot_r [NUM_OPS];

    // Slot storage: write the indexed slot, clear the rest when a group starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                slot_r[i] <= {ADDER_WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (IDX_BITS'(i) == wr_idx) begin
                    slot_r[i] <= wr_data;
                end else if (wr_idx == {IDX_BITS{1'b0}}) begin
                    slot_r[i] <= {ADDER_WIDTH{1'b0}};
                end
            end
        end
    end

    // Pack the slots onto the tree bus, slot 0 in the LSBs.
    always_comb begin
        op_bus = {(NUM_OPS*ADDER_WIDTH){1'b0}};
        for (int i = 0; i < NUM_OPS; i++) begin
            op_bus[i*ADDER_WIDTH +: ADDER_WIDTH] = slot_r[i];
        end
    end

endmodule

// File: rtl/adder_tree_sequencer.sv
// Collects an operand group, launches it to the registered adder tree, waits out the
// tree latency and presents the captured sum on a valid/ready result port.
module adder_tree_sequencer
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int NUM_OPS     = DEF_NUM_OPS,
    parameter int TREE_LAT    = DEF_TREE_LAT
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [ADDER_WIDTH-1:0]                    in_data,
    input  logic                                      in_last,
    output logic [NUM_OPS*ADDER_WIDTH-1:0]            op_bus,
    output logic                                      op_valid,
    input  logic [ADDER_WIDTH+$clog2(NUM_OPS)-1:0]    tree_sum,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [ADDER_WIDTH+$clog2(NUM_OPS)-1:0]    res_data,
    output logic [$clog2(NUM_OPS):0]                  res_count
);

    localparam int SUM_BITS = ADDER_WIDTH + $clog2(NUM_OPS);
    localparam int IDX_BITS = $clog2(NUM_OPS);
    localparam int CNT_BITS = IDX_BITS + 1;
    localparam int LAT_BITS = $clog2(TREE_LAT + 1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [IDX_BITS-1:0]   idx_r;
    logic [CNT_BITS-1:0]   grp_cnt_r;
    logic [LAT_BITS-1:0]   lat_cnt_r;
    logic                  op_valid_r;
    logic                  res_valid_r;
    logic [SUM_BITS-1:0]   res_data_r;
    logic [CNT_BITS-1:0]   res_count_r;

    logic                  xfer_s;
    logic                  last_xfer_s;
    logic                  lat_done_s;
    logic                  handshake_s;

    assign in_ready    = (state_r == FILL);
    assign xfer_s      = in_valid & in_ready;
    assign last_xfer_s = xfer_s & (in_last | (idx_r == IDX_BITS'(NUM_OPS - 1)));
    assign lat_done_s  = (lat_cnt_r == {LAT_BITS{1'b0}});
    assign handshake_s = res_valid_r & res_ready;

    assign op_valid  = op_valid_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_count = res_count_r;

    adder_tree_operand_bank #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .NUM_OPS     (NUM_OPS)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (xfer_s),
        .wr_idx  (idx_r),
        .wr_data (in_data),
        .op_bus  (op_bus)
    );

    // Next-state decode for the fill/launch/wait/hold sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FILL: begin
                if (last_xfer_s) state_nxt_s = LAUNCH;
                else             state_nxt_s = FILL;
            end
            LAUNCH: state_nxt_s = WAIT;
            WAIT: begin
                if (lat_done_s) state_nxt_s = HOLD;
                else            state_nxt_s = WAIT;
            end
            HOLD: begin
                if (handshake_s) state_nxt_s = FILL;
                else             state_nxt_s = HOLD;
            end
            default: state_nxt_s = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Slot index and operand count for the group being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= {IDX_BITS{1'b0}};
            grp_cnt_r <= {CNT_BITS{1'b0}};
        end else begin
            if (xfer_s) begin
                idx_r <= idx_r + IDX_BITS'(1);
            end else if (handshake_s) begin
                idx_r <= {IDX_BITS{1'b0}};
            end
            if (last_xfer_s) begin
                grp_cnt_r <= {1'b0, idx_r} + CNT_BITS'(1);
            end
        end
    end

    // Launch strobe and tree latency countdown; count reaches zero in the cycle tree_sum is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_r <= 1'b0;
            lat_cnt_r  <= {LAT_BITS{1'b0}};
        end else begin
            op_valid_r <= (state_nxt_s == LAUNCH);
            if (state_r == LAUNCH) begin
                lat_cnt_r <= LAT_BITS'(TREE_LAT - 1);
            end else if ((state_r == WAIT) && !lat_done_s) begin
                lat_cnt_r <= lat_cnt_r - LAT_BITS'(1);
            end
        end
    end

    // Result capture and valid/ready holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {SUM_BITS{1'b0}};
            res_count_r <= {CNT_BITS{1'b0}};
        end else if ((state_r == WAIT) && lat_done_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= tree_sum;
            res_count_r <= grp_cnt_r;
        end else if (handshake_s) begin
            res_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed self-checking bench; the adder tree is modelled as a two-stage registered adder.
module tb_adder_tree_sequencer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [10:0]   in_data = 11'd0;
    logic          in_last = 1'b0;
    logic [87:0]   op_bus;
    logic          op_valid;
    logic [13:0]   tree_sum = 14'd0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [13:0]   res_data;
    logic [3:0]    res_count;

    logic [13:0]   stage1 = 14'd0;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            opv_cnt = 0;
    int            last_edge = 0;

    adder_tree_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .op_bus    (op_bus),
        .op_valid  (op_valid),
        .tree_sum  (tree_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] bus_sum(input logic [87:0] b);
        logic [13:0] s;
        s = 14'd0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, b[i*11 +: 11]};
        return s;
    endfunction

    always @(posedge clk) begin
        stage1   <= bus_sum(op_bus);
        tree_sum <= stage1;
        cyc      <= cyc + 1;
    end

    always @(negedge clk) begin
        if (op_valid) opv_cnt <= opv_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [10:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        last_edge = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_res_valid"}, {127'd0, res_valid}, 128'd1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, {127'd0, res_valid}, 128'd0);
        check({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        int opv_base;
        int seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_valid", {127'd0, op_valid}, 128'd0);
        check("rst_res_valid", {127'd0, res_valid}, 128'd0);
        check("rst_res_data", {114'd0, res_data}, 128'd0);
        check("rst_res_count", {124'd0, res_count}, 128'd0);
        check("rst_op_bus", {40'd0, op_bus}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;

        // Full group 1..8 streamed back-to-back
        opv_base = opv_cnt;
        for (int i = 1; i <= 8; i++) send(11'(i), (i == 8) ? 1'b1 : 1'b0);
        wait_result("full");
        check("full_latency", 128'(cyc - last_edge), 128'd3);
        check("full_data", {114'd0, res_data}, 128'd36);
        check("full_count", {124'd0, res_count}, 128'd8);
        check("full_opv_once", 128'(opv_cnt - opv_base), 128'd1);
        handshake("full");

        // All-ones operands, no overflow loss
        for (int i = 0; i < 8; i++) send(11'h7FF, 1'b0);
        wait_result("max");
        check("max_data", {114'd0, res_data}, 128'h3FF8);
        check("max_count", {124'd0, res_count}, 128'd8);
        handshake("max");

        // Short group after full group of 0x7FF: stale slots must be zero
        opv_base = opv_cnt;
        send(11'd5, 1'b0);
        send(11'd6, 1'b1);
        check("short_op_bus", {40'd0, op_bus}, 128'h3005);
        wait_result("short");
        check("short_latency", 128'(cyc - last_edge), 128'd3);
        check("short_data", {114'd0, res_data}, 128'd11);
        check("short_count", {124'd0, res_count}, 128'd2);
        check("short_opv_once", 128'(opv_cnt - opv_base), 128'd1);
        handshake("short");

        // Back-pressure: result held for 10 cycles
        send(11'd1, 1'b0);
        send(11'd2, 1'b0);
        send(11'd3, 1'b1);
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_data_stable", {114'd0, res_data}, 128'd6);
            check("bp_valid_held", {127'd0, res_valid}, 128'd1);
            check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
        end
        check("bp_count", {124'd0, res_count}, 128'd3);
        handshake("bp");

        // Reset during WAIT discards the group
        send(11'd10, 1'b0);
        send(11'd20, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_op_valid", {127'd0, op_valid}, 128'd0);
        check("mid_rst_res_valid", {127'd0, res_valid}, 128'd0);
        check("mid_rst_res_data", {114'd0, res_data}, 128'd0);
        check("mid_rst_res_count", {124'd0, res_count}, 128'd0);
        check("mid_rst_op_bus", {40'd0, op_bus}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        check("mid_rst_no_result", 128'(seen), 128'd0);
        send(11'd100, 1'b0);
        send(11'd200, 1'b0);
        send(11'd300, 1'b1);
        wait_result("post_rst");
        check("post_rst_data", {114'd0, res_data}, 128'd600);
        check("post_rst_count", {124'd0, res_count}, 128'd3);
        handshake("post_rst");

        // Single-operand group
        send(11'h123, 1'b1);
        wait_result("single");
        check("single_data", {114'd0, res_data}, 128'h123);
        check("single_count", {124'd0, res_count}, 128'd1);
        handshake("single");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
